// File: rtl/reset_sequencer.sv
// Reset sequencer: holds NUM_CH downstream reset domains low for a fixed
// interval, waits for fabric/MSS ready, then releases the domains one at a
// time in index order with a fixed stagger. It retries when ready times out,
// accepts a software re-reset request, and aborts if ready is lost.
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int STAGE_GAP      = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              ready_in,
  input  logic              sw_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        retry_cnt
);

  localparam int STG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    WAIT_READY = 2'd1,
    RELEASE    = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STG_W-1:0]    stage_q, stage_d;
  logic [STG_W:0]      stage_inc;
  logic [NUM_CH-1:0]   rst_n_d;
  logic                busy_d, done_d, timeout_d;
  logic [7:0]          retry_d;

  // The incremented stage is one bit wider so the last-stage compare never wraps.
  assign stage_inc = {1'b0, stage_q} + {{STG_W{1'b0}}, 1'b1};

  // Next-state and next-output logic; priority: sw_req, ready loss, timeout, normal.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_n_d   = rst_n_out;
    timeout_d = timeout;
    retry_d   = retry_cnt;

    if (sw_req || (!ready_in && (state_q == RELEASE || state_q == RUN))) begin
      state_d = HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rst_n_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = WAIT_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_READY: begin
          if (ready_in) begin
            cnt_d      = '0;
            stage_d    = '0;
            rst_n_d[0] = 1'b1;
            if (NUM_CH == 1) state_d = RUN;
            else             state_d = RELEASE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = HOLD;
            cnt_d     = '0;
            timeout_d = 1'b1;
            if (retry_cnt != 8'hFF) retry_d = retry_cnt + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_d   = '0;
            stage_d = stage_inc[STG_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
              if (stage_inc == (STG_W+1)'(i)) rst_n_d[i] = 1'b1;
            end
            if (stage_inc == (STG_W+1)'(NUM_CH - 1)) state_d = RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          // Domains stay released until sw_req or ready loss.
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_n_d = '0;
        end
      endcase
    end

    busy_d = (state_d != RUN);
    done_d = (state_d == RUN);
  end

  // State, counter and registered outputs with synchronous active-high reset.
  always_ff @(posedge SYSCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (SYSRESET) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      retry_cnt <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_n_out <= rst_n_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= timeout_d;
      retry_cnt <= retry_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three instances cover the default
// configuration, a short ready timeout, and a single-channel minimum setup.
module tb_reset_sequencer;

  logic SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Instance A: defaults.
  logic       rst_a = 1'b1, rdy_a = 1'b0, sw_a = 1'b0;
  logic [3:0] rn_a;
  logic       busy_a, done_a, to_a;
  logic [7:0] rc_a;

  // Instance B: TIMEOUT_CYCLES = 20.
  logic       rst_b = 1'b1, rdy_b = 1'b0, sw_b = 1'b0;
  logic [3:0] rn_b;
  logic       busy_b, done_b, to_b;
  logic [7:0] rc_b;

  // Instance C: one channel, minimum intervals.
  logic       rst_c = 1'b1, rdy_c = 1'b0, sw_c = 1'b0;
  logic [0:0] rn_c;
  logic       busy_c, done_c, to_c;
  logic [7:0] rc_c;

  reset_sequencer dut_a (
    .SYSCLK(SYSCLK), .SYSRESET(rst_a), .ready_in(rdy_a), .sw_req(sw_a),
    .rst_n_out(rn_a), .busy(busy_a), .done(done_a), .timeout(to_a), .retry_cnt(rc_a)
  );

  reset_sequencer #(.TIMEOUT_CYCLES(20)) dut_b (
    .SYSCLK(SYSCLK), .SYSRESET(rst_b), .ready_in(rdy_b), .sw_req(sw_b),
    .rst_n_out(rn_b), .busy(busy_b), .done(done_b), .timeout(to_b), .retry_cnt(rc_b)
  );

  reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .TIMEOUT_CYCLES(1)) dut_c (
    .SYSCLK(SYSCLK), .SYSRESET(rst_c), .ready_in(rdy_c), .sw_req(sw_c),
    .rst_n_out(rn_c), .busy(busy_c), .done(done_c), .timeout(to_c), .retry_cnt(rc_c)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge SYSCLK);
    #1;
    edge_no++;
  endtask

  task automatic run_to(input int n);
    while (edge_no < n) tick();
  endtask

  initial begin
    // ---- A: reset values, then full release with ready held high ----
    rdy_a = 1'b1;
    tick(); tick();
    check("a_rst_rn",    32'(rn_a),   32'h0);
    check("a_rst_busy",  32'(busy_a), 32'h1);
    check("a_rst_done",  32'(done_a), 32'h0);
    check("a_rst_to",    32'(to_a),   32'h0);
    check("a_rst_retry", 32'(rc_a),   32'h0);
    rst_a = 1'b0; edge_no = 0;
    run_to(10); check("a_e10_rn",  32'(rn_a), 32'h0);
    run_to(11); check("a_e11_rn",  32'(rn_a), 32'h1);
    run_to(14); check("a_e14_rn",  32'(rn_a), 32'h1);
    run_to(15); check("a_e15_rn",  32'(rn_a), 32'h3);
    run_to(19); check("a_e19_rn",  32'(rn_a), 32'h7);
    run_to(22); check("a_e22_done", 32'(done_a), 32'h0);
                check("a_e22_busy", 32'(busy_a), 32'h1);
    run_to(23); check("a_e23_rn",   32'(rn_a),   32'hF);
                check("a_e23_done", 32'(done_a), 32'h1);
                check("a_e23_busy", 32'(busy_a), 32'h0);
                check("a_e23_to",   32'(to_a),   32'h0);
                check("a_e23_retry", 32'(rc_a),  32'h0);

    // ---- A: ready loss mid-release, then restart with a full hold ----
    rst_a = 1'b1; tick(); rst_a = 1'b0; edge_no = 0;
    run_to(15); check("ab_e15_rn", 32'(rn_a), 32'h3);
    run_to(17); rdy_a = 1'b0;
    run_to(18); check("ab_e18_rn",   32'(rn_a),   32'h0);
                check("ab_e18_busy", 32'(busy_a), 32'h1);
    rdy_a = 1'b1;
    run_to(28); check("ab_e28_rn", 32'(rn_a), 32'h0);
    run_to(29); check("ab_e29_rn", 32'(rn_a), 32'h1);
    run_to(40); check("ab_e40_done", 32'(done_a), 32'h0);
    run_to(41); check("ab_e41_rn",   32'(rn_a),   32'hF);
                check("ab_e41_done", 32'(done_a), 32'h1);

    // ---- A: sw_req in RUN, second sw_req 5 cycles into HOLD ----
    sw_a = 1'b1;
    run_to(42); sw_a = 1'b0;
                check("sw_e42_rn",   32'(rn_a),   32'h0);
                check("sw_e42_busy", 32'(busy_a), 32'h1);
                check("sw_e42_done", 32'(done_a), 32'h0);
    run_to(46); sw_a = 1'b1;
    run_to(47); sw_a = 1'b0;
    run_to(53); check("sw_e53_rn", 32'(rn_a), 32'h0);
    run_to(57); check("sw_e57_rn", 32'(rn_a), 32'h0);
    run_to(58); check("sw_e58_rn", 32'(rn_a), 32'h1);
    rst_a = 1'b1;

    // ---- B: two ready timeouts, then release; SYSRESET mid-release ----
    tick();
    rst_b = 1'b0; rdy_b = 1'b0; edge_no = 0;
    run_to(29); check("b_e29_to",    32'(to_b), 32'h0);
                check("b_e29_retry", 32'(rc_b), 32'h0);
    run_to(30); check("b_e30_to",    32'(to_b), 32'h1);
                check("b_e30_retry", 32'(rc_b), 32'h1);
    run_to(59); check("b_e59_retry", 32'(rc_b), 32'h1);
    run_to(60); check("b_e60_retry", 32'(rc_b), 32'h2);
    run_to(70); check("b_e70_rn",    32'(rn_b), 32'h0);
    rdy_b = 1'b1;
    run_to(71); check("b_e71_rn",    32'(rn_b), 32'h1);
                check("b_e71_to",    32'(to_b), 32'h1);
                check("b_e71_retry", 32'(rc_b), 32'h2);
    run_to(72); rst_b = 1'b1;
    run_to(73); check("b_sr_rn",    32'(rn_b),   32'h0);
                check("b_sr_busy",  32'(busy_b), 32'h1);
                check("b_sr_done",  32'(done_b), 32'h0);
                check("b_sr_to",    32'(to_b),   32'h0);
                check("b_sr_retry", 32'(rc_b),   32'h0);

    // ---- C: single channel, then retry_cnt saturation ----
    rst_c = 1'b0; rdy_c = 1'b1; edge_no = 0;
    run_to(1); check("c_e1_rn",   32'(rn_c),   32'h0);
               check("c_e1_done", 32'(done_c), 32'h0);
    run_to(2); check("c_e2_rn",   32'(rn_c),   32'h1);
               check("c_e2_done", 32'(done_c), 32'h1);
               check("c_e2_busy", 32'(busy_c), 32'h0);
    rdy_c = 1'b0;
    run_to(3);   check("c_e3_rn",      32'(rn_c), 32'h0);
    run_to(4);   check("c_e4_retry",   32'(rc_c), 32'h0);
    run_to(5);   check("c_e5_retry",   32'(rc_c), 32'h1);
                 check("c_e5_to",      32'(to_c), 32'h1);
    run_to(511); check("c_e511_retry", 32'(rc_c), 32'd254);
    run_to(513); check("c_e513_retry", 32'(rc_c), 32'd255);
    run_to(620); check("c_e620_retry", 32'(rc_c), 32'd255);
                 check("c_e620_to",    32'(to_c), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
